// File: rtl/count8_down_if.sv
// Control/status bundle for the loadable 3-bit down-counter.
// The master drives load/count controls; the slave reports count state.
interface count8_down_if;
    logic       load;
    logic [2:0] din;
    logic       en;
    logic       auto;
    logic [2:0] cnt8;
    logic       zero;
    logic       tc;
    logic       busy;

    modport master (
        output load, din, en, auto,
        input  cnt8, zero, tc, busy
    );

    modport slave (
        input  load, din, en, auto,
        output cnt8, zero, tc, busy
    );
endinterface

// File: rtl/count8_down.sv
// Loadable 3-bit down-counter with terminal-count pulse.
// Auto mode reloads on expiry; one-shot mode drops back to IDLE.
module count8_down #(
    parameter logic [2:0] RELOAD_DEFAULT = 3'd7
) (
    input  logic         clk,
    input  logic         rst,
    count8_down_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [2:0] reload_q;
    logic       tc_q;
    logic [2:0] cnt_dec_d;

    assign cnt_dec_d = cnt_q - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            reload_q <= RELOAD_DEFAULT;
            tc_q     <= 1'b0;
        end else if (bus.load) begin
            state_q  <= RUN;
            cnt_q    <= bus.din;
            reload_q <= bus.din;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                RUN: begin
                    if (bus.en) begin
                        if (cnt_q != 3'd0) begin
                            cnt_q <= cnt_dec_d;
                        end else begin
                            // expiry: auto only matters on this edge
                            tc_q <= 1'b1;
                            if (bus.auto) begin
                                cnt_q <= reload_q;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cnt8 = cnt_q;
    assign bus.zero = (cnt_q == 3'd0);
    assign bus.tc   = tc_q;
    assign bus.busy = (state_q == RUN);
endmodule

// File: tb/tb_count8_down.sv
// Self-checking bench for count8_down: directed scenarios with
// literal expectations plus randomized traffic against a model.
module tb_count8_down;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    count8_down_if bus_if ();

    count8_down #(
        .RELOAD_DEFAULT(3'd7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int m_cnt;
    int m_rel;
    bit m_run;
    bit m_tc;
    bit m_ok;

    initial begin
        m_ok  = 1'b0;
        m_cnt = 0;
        m_rel = 7;
        m_run = 1'b0;
        m_tc  = 1'b0;
    end

    // Reference: plain integer bookkeeping of the count rules
    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            m_rel = 7;
            m_run = 1'b0;
            m_tc  = 1'b0;
            m_ok  = 1'b1;
        end else if (bus_if.load) begin
            m_cnt = int'(bus_if.din);
            m_rel = int'(bus_if.din);
            m_run = 1'b1;
            m_tc  = 1'b0;
        end else if (m_run && bus_if.en) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                m_tc  = 1'b0;
            end else begin
                m_tc = 1'b1;
                if (bus_if.auto) m_cnt = m_rel;
                else m_run = 1'b0;
            end
        end else begin
            m_tc = 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            check("model_cnt8", int'(bus_if.cnt8), m_cnt);
            check("model_zero", int'(bus_if.zero), int'(m_cnt == 0));
            check("model_tc", int'(bus_if.tc), int'(m_tc));
            check("model_busy", int'(bus_if.busy), int'(m_run));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit ld, input int d,
                         input bit e, input bit a);
        rst           = r;
        bus_if.load   = ld;
        bus_if.din    = 3'(d);
        bus_if.en     = e;
        bus_if.auto   = a;
    endtask

    int pulses;
    int en_edges;
    int first_tc;
    bit e;

    initial begin
        total = 0;
        bad   = 0;
        drive(1, 1, 5, 1, 0);
        tick();
        tick();
        check("rst_cnt8", int'(bus_if.cnt8), 0);
        check("rst_zero", int'(bus_if.zero), 1);
        check("rst_tc", int'(bus_if.tc), 0);
        check("rst_busy", int'(bus_if.busy), 0);

        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_cnt8", int'(bus_if.cnt8), 0);
            check("idle_tc", int'(bus_if.tc), 0);
        end

        // one-shot from 5
        drive(0, 1, 5, 1, 0);
        tick();
        check("os_load", int'(bus_if.cnt8), 5);
        check("os_busy", int'(bus_if.busy), 1);
        drive(0, 0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("os_cnt8", int'(bus_if.cnt8), 5 - k);
            check("os_tc_low", int'(bus_if.tc), 0);
        end
        tick();
        check("os_tc", int'(bus_if.tc), 1);
        check("os_busy_fall", int'(bus_if.busy), 0);
        tick();
        check("os_tc_once", int'(bus_if.tc), 0);
        check("os_hold", int'(bus_if.cnt8), 0);

        // free-running mod-8
        drive(0, 1, 7, 1, 1);
        tick();
        drive(0, 0, 0, 1, 1);
        pulses = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (bus_if.tc) pulses++;
            check("fr_cnt8", int'(bus_if.cnt8), (k % 8 == 0) ? 7 : 7 - (k % 8));
        end
        check("fr_pulses", pulses, 3);

        // enable gaps, one-shot from 3
        drive(0, 1, 3, 1, 0);
        tick();
        en_edges = 0;
        first_tc = -1;
        for (int k = 0; k < 12; k++) begin
            e = (k % 2 == 0);
            drive(0, 0, 0, e, 0);
            tick();
            if (e) en_edges++;
            if (bus_if.tc && first_tc < 0) first_tc = en_edges;
        end
        check("gap_tc_edges", first_tc, 4);

        // load collides with expiry
        drive(0, 1, 4, 1, 1);
        tick();
        drive(0, 0, 0, 1, 1);
        for (int k = 0; k < 4; k++) tick();
        check("col_zero", int'(bus_if.cnt8), 0);
        drive(0, 1, 2, 1, 1);
        tick();
        check("col_cnt8", int'(bus_if.cnt8), 2);
        check("col_tc", int'(bus_if.tc), 0);
        drive(0, 0, 0, 1, 1);
        tick();
        tick();
        tick();
        check("col_tc2", int'(bus_if.tc), 1);
        check("col_reload", int'(bus_if.cnt8), 2);

        // mid-count reset then din=0 load
        drive(0, 1, 6, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        tick();
        tick();
        tick();
        check("mr_cnt3", int'(bus_if.cnt8), 3);
        drive(1, 0, 0, 1, 0);
        tick();
        check("mr_cnt8", int'(bus_if.cnt8), 0);
        check("mr_busy", int'(bus_if.busy), 0);
        check("mr_tc", int'(bus_if.tc), 0);
        drive(0, 1, 0, 1, 0);
        tick();
        check("mr_busy0", int'(bus_if.busy), 1);
        drive(0, 0, 0, 1, 0);
        tick();
        check("mr_tc0", int'(bus_if.tc), 1);

        // randomized traffic, model-checked every cycle
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1) == 1);
            tick();
        end

        drive(0, 0, 0, 0, 0);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
